branch_resolve_unit: RTL and testbench

//  Resolves conditional branches against NUM_BANKS banked 4-bit condition-code registers {v,c,n,z}.

---
 rtl/branch_resolve_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution against banked {v,c,n,z} condition-code registers, with
// per-bank in-flight flag-writer tracking and a registered redirect result.
module branch_resolve_unit #(
   parameter  int NUM_BANKS   = 2,
   parameter  int MAX_PENDING = 3,
   parameter  int PC_W        = 32,
   localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 cc_pend_inc,
   input  logic [BANK_W-1:0]    cc_pend_bank,
   output logic [NUM_BANKS-1:0] cc_pend_full,
   input  logic                 cc_wr_en,
   input  logic [BANK_W-1:0]    cc_wr_bank,
   input  logic [3:0]           cc_wr_data,
   input  logic                 br_valid,
   output logic                 br_ready,
   input  logic [BANK_W-1:0]    br_bank,
   input  logic [3:0]           br_cond,
   input  logic                 br_pred_taken,
   input  logic [PC_W-1:0]      br_target,
   input  logic [PC_W-1:0]      br_fallthru,
   output logic                 res_valid,
   output logic                 res_taken,
   output logic                 res_mispredict,
   output logic [PC_W-1:0]      res_pc,
   output logic                 dbg_state
);

   // Branch handshake: a branch transfers on a rising edge where br_valid and
   // br_ready are both high and flush is low; the result is a one-cycle strobe.
   typedef enum logic {ST_IDLE = 1'b0, ST_EVAL = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cc_q   [NUM_BANKS];
   logic [3:0]          cc_d   [NUM_BANKS];
   logic [CNT_W-1:0]    pend_q [NUM_BANKS];
   logic [CNT_W-1:0]    pend_d [NUM_BANKS];
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic [3:0]          cond_q, cond_d;
   logic                pred_q, pred_d;
   logic [PC_W-1:0]     tgt_q, tgt_d;
   logic [PC_W-1:0]     ft_q, ft_d;
   logic                res_valid_q, res_valid_d;
   logic                res_taken_q, res_taken_d;
   logic                res_mis_q, res_mis_d;
   logic [PC_W-1:0]     res_pc_q, res_pc_d;

   logic [CNT_W-1:0]    sel_pend;
   logic                bypass;
   logic                flags_ready;
   logic [3:0]          sel_flags;
   logic                taken_now;

   // Flags are {v,c,n,z}; cond[3] inverts the base test, except 3'b111 is never.
   function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
      logic z, n, c, v, base;
      z = f[0];
      n = f[1];
      c = f[2];
      v = f[3];
      case (cond[2:0])
         3'b000:  base = 1'b1;
         3'b001:  base = ~c;
         3'b010:  base = ~v;
         3'b011:  base = z;
         3'b100:  base = (n == v);
         3'b101:  base = ~z & (n == v);
         3'b110:  base = ~n;
         default: base = 1'b0;
      endcase
      return (cond[2:0] == 3'b111) ? 1'b0 : (base ^ cond[3]);
   endfunction

   assign sel_pend    = pend_q[bank_q];
   // The last outstanding writer landing this cycle lets us resolve on its data.
   assign bypass      = cc_wr_en && (cc_wr_bank == bank_q) && (sel_pend == CNT_W'(1));
   assign flags_ready = (sel_pend == '0) || bypass;
   assign sel_flags   = bypass ? cc_wr_data : cc_q[bank_q];
   assign taken_now   = eval_cond(cond_q, sel_flags);

   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      cond_d      = cond_q;
      pred_d      = pred_q;
      tgt_d       = tgt_q;
      ft_d        = ft_q;
      res_valid_d = 1'b0;
      res_taken_d = res_taken_q;
      res_mis_d   = res_mis_q;
      res_pc_d    = res_pc_q;

      for (int b = 0; b < NUM_BANKS; b++) begin
         logic inc_b, wr_b;
         inc_b     = cc_pend_inc && (cc_pend_bank == BANK_W'(b));
         wr_b      = cc_wr_en && (cc_wr_bank == BANK_W'(b));
         cc_d[b]   = wr_b ? cc_wr_data : cc_q[b];
         pend_d[b] = pend_q[b];
         if (flush) begin
            pend_d[b] = '0;
         end else if (inc_b && !wr_b && (pend_q[b] != CNT_W'(MAX_PENDING))) begin
            pend_d[b] = pend_q[b] + CNT_W'(1);
         end else if (wr_b && !inc_b && (pend_q[b] != '0)) begin
            pend_d[b] = pend_q[b] - CNT_W'(1);
         end
      end

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (br_valid) begin
                  bank_d  = br_bank;
                  cond_d  = br_cond;
                  pred_d  = br_pred_taken;
                  tgt_d   = br_target;
                  ft_d    = br_fallthru;
                  state_d = ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (flags_ready) begin
                  res_valid_d = 1'b1;
                  res_taken_d = taken_now;
                  res_mis_d   = taken_now ^ pred_q;
                  res_pc_d    = taken_now ? tgt_q : ft_q;
                  state_d     = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bank_q      <= '0;
         cond_q      <= '0;
         pred_q      <= 1'b0;
         tgt_q       <= '0;
         ft_q        <= '0;
         res_valid_q <= 1'b0;
         res_taken_q <= 1'b0;
         res_mis_q   <= 1'b0;
         res_pc_q    <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            cc_q[b]   <= 4'b0000;
            pend_q[b] <= '0;
         end
      end else begin
         state_q     <= state_d;
         bank_q      <= bank_d;
         cond_q      <= cond_d;
         pred_q      <= pred_d;
         tgt_q       <= tgt_d;
         ft_q        <= ft_d;
         res_valid_q <= res_valid_d;
         res_taken_q <= res_taken_d;
         res_mis_q   <= res_mis_d;
         res_pc_q    <= res_pc_d;
         for (int b = 0; b < NUM_BANKS; b++) begin
            cc_q[b]   <= cc_d[b];
            pend_q[b] <= pend_d[b];
         end
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         cc_pend_full[b] = (pend_q[b] == CNT_W'(MAX_PENDING));
      end
   end

   assign br_ready       = (state_q == ST_IDLE);
   assign dbg_state      = (state_q == ST_EVAL);
   assign res_valid      = res_valid_q;
   assign res_taken      = res_taken_q;
   assign res_mispredict = res_mis_q;
   assign res_pc         = res_pc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a condition table plus hand
// sequences for stalls, bypass, pending saturation, flush and mid-EVAL reset.
module tb_branch_resolve_unit;

   localparam int NB = 2;
   localparam int PW = 32;
   localparam int BW = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          cc_pend_inc;
   logic [BW-1:0] cc_pend_bank;
   logic [NB-1:0] cc_pend_full;
   logic          cc_wr_en;
   logic [BW-1:0] cc_wr_bank;
   logic [3:0]    cc_wr_data;
   logic          br_valid;
   logic          br_ready;
   logic [BW-1:0] br_bank;
   logic [3:0]    br_cond;
   logic          br_pred_taken;
   logic [PW-1:0] br_target;
   logic [PW-1:0] br_fallthru;
   logic          res_valid;
   logic          res_taken;
   logic          res_mispredict;
   logic [PW-1:0] res_pc;
   logic          dbg_state;

   branch_resolve_unit #(.NUM_BANKS(NB), .MAX_PENDING(3), .PC_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .cc_pend_inc(cc_pend_inc), .cc_pend_bank(cc_pend_bank), .cc_pend_full(cc_pend_full),
      .cc_wr_en(cc_wr_en), .cc_wr_bank(cc_wr_bank), .cc_wr_data(cc_wr_data),
      .br_valid(br_valid), .br_ready(br_ready), .br_bank(br_bank), .br_cond(br_cond),
      .br_pred_taken(br_pred_taken), .br_target(br_target), .br_fallthru(br_fallthru),
      .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
      .res_pc(res_pc), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [3:0] flags;
      logic [3:0] cond;
      logic       exp_taken;
   } vec_t;

   vec_t          vecs[15];
   logic [PW+1:0] exp_q[$];
   logic [PW+1:0] mon_e;
   logic          mon_prev;
   int            n_vec;
   int            n_bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [BW-1:0] bank, input logic [3:0] f);
      cc_wr_en   = 1'b1;
      cc_wr_bank = bank;
      cc_wr_data = f;
      tick();
      cc_wr_en   = 1'b0;
   endtask

   task automatic pend_inc(input logic [BW-1:0] bank);
      cc_pend_inc  = 1'b1;
      cc_pend_bank = bank;
      tick();
      cc_pend_inc  = 1'b0;
   endtask

   task automatic send_br(input logic [BW-1:0] bank, input logic [3:0] cond, input logic pred,
                          input logic [PW-1:0] tgt, input logic [PW-1:0] ft,
                          input logic exp_taken, input logic push);
      for (int i = 0; i < 20 && !br_ready; i++) tick();
      if (!br_ready) check("br_ready_wait", 64'(br_ready), 64'd1);
      br_valid      = 1'b1;
      br_bank       = bank;
      br_cond       = cond;
      br_pred_taken = pred;
      br_target     = tgt;
      br_fallthru   = ft;
      if (push) exp_q.push_back({exp_taken, exp_taken ^ pred, exp_taken ? tgt : ft});
      tick();
      br_valid      = 1'b0;
   endtask

   task automatic wait_done();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (exp_q.size() != 0) begin
         check("result_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      tick();
   endtask

   // ---------------- test ----------------
   initial begin
      logic [PW-1:0] tgt, ft;
      logic          pred;

      n_vec = 0;
      n_bad = 0;
      mon_prev = 1'b0;
      vecs[0]  = '{4'b0010, 4'b1100, 1'b1};  // n=1 v=0 BLT
      vecs[1]  = '{4'b0010, 4'b0100, 1'b0};  // BGE
      vecs[2]  = '{4'b1011, 4'b0101, 1'b0};  // n=v=z=1 BGT
      vecs[3]  = '{4'b1011, 4'b1101, 1'b1};  // BLE
      vecs[4]  = '{4'b1111, 4'b0111, 1'b0};
      vecs[5]  = '{4'b1111, 4'b1111, 1'b0};
      vecs[6]  = '{4'b0000, 4'b0000, 1'b1};
      vecs[7]  = '{4'b0000, 4'b1000, 1'b0};
      vecs[8]  = '{4'b0100, 4'b1001, 1'b1};
      vecs[9]  = '{4'b0100, 4'b0001, 1'b0};
      vecs[10] = '{4'b1000, 4'b1010, 1'b1};
      vecs[11] = '{4'b1000, 4'b0010, 1'b0};
      vecs[12] = '{4'b0000, 4'b0110, 1'b1};
      vecs[13] = '{4'b0010, 4'b1110, 1'b1};
      vecs[14] = '{4'b0001, 4'b1011, 1'b0};

      rst_n = 1'b0; flush = 1'b0; cc_pend_inc = 1'b0; cc_pend_bank = '0;
      cc_wr_en = 1'b0; cc_wr_bank = '0; cc_wr_data = '0; br_valid = 1'b0;
      br_bank = '0; br_cond = '0; br_pred_taken = 1'b0; br_target = '0; br_fallthru = '0;

      // result monitor: pops the expected queue on every result strobe
      fork
         forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
               check("res_valid_one_cycle", 64'(mon_prev), 64'd0);
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 64'd1, 64'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("result", 64'({res_taken, res_mispredict, res_pc}), 64'(mon_e));
               end
            end
            mon_prev = rst_n && res_valid;
         end
      join_none

      repeat (3) @(negedge clk);
      check("rst_br_ready", 64'(br_ready), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_taken", 64'(res_taken), 64'd0);
      check("rst_res_pc", 64'(res_pc), 64'd0);
      check("rst_pend_full", 64'(cc_pend_full), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // bank0 z=1, BEQ predicted not-taken: latency and mispredict
      set_flags(0, 4'b0001);
      tgt = 32'h0000_1000; ft = 32'h0000_0ff4;
      send_br(0, 4'b0011, 1'b0, tgt, ft, 1'b1, 1'b1);
      @(negedge clk);
      check("lat_e0_valid", 64'(res_valid), 64'd0);
      check("lat_e0_ready", 64'(br_ready), 64'd0);
      @(negedge clk);
      check("lat_e1_valid", 64'(res_valid), 64'd1);
      @(negedge clk);
      check("lat_e2_valid", 64'(res_valid), 64'd0);
      check("lat_e2_ready", 64'(br_ready), 64'd1);
      check("lat_q_drained", 64'(exp_q.size()), 64'd0);
      tick();

      // stall on bank1 pending, released by same-cycle bypass writeback
      pend_inc(1);
      send_br(1, 4'b1011, 1'b0, 32'h0000_2000, 32'h0000_2004, 1'b1, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", 64'(res_valid), 64'd0);
         check("stall_ready", 64'(br_ready), 64'd0);
      end
      tick();
      set_flags(1, 4'b0000);
      wait_done();

      // condition table on bank0
      for (int i = 0; i < 15; i++) begin
         set_flags(0, vecs[i].flags);
         pred = 1'($urandom_range(0, 1));
         tgt  = $urandom;
         ft   = $urandom;
         send_br(0, vecs[i].cond, pred, tgt, ft, vecs[i].exp_taken, 1'b1);
         wait_done();
      end

      // pending saturation and inc+wr in the same cycle
      repeat (3) pend_inc(0);
      @(negedge clk);
      check("full_at_max", 64'(cc_pend_full), 64'b01);
      tick();
      pend_inc(0);
      @(negedge clk);
      check("full_extra_inc", 64'(cc_pend_full), 64'b01);
      tick();
      cc_pend_inc = 1'b1; cc_pend_bank = 0;
      set_flags(0, 4'b0000);
      cc_pend_inc = 1'b0;
      @(negedge clk);
      check("full_inc_wr", 64'(cc_pend_full), 64'b01);
      tick();
      set_flags(0, 4'b0000);
      @(negedge clk);
      check("full_after_wr", 64'(cc_pend_full), 64'b00);
      tick();
      set_flags(0, 4'b0000);
      send_br(0, 4'b0000, 1'b1, 32'h0000_3000, 32'h0000_3004, 1'b1, 1'b1);
      repeat (2) begin
         @(negedge clk);
         check("pend1_stall", 64'(res_valid), 64'd0);
      end
      tick();
      set_flags(0, 4'b0000);
      wait_done();

      // flush while stalled; branch presented with flush is dropped
      set_flags(0, 4'b0001);
      pend_inc(0);
      send_br(0, 4'b0011, 1'b0, 32'h0000_4000, 32'h0000_4004, 1'b1, 1'b0);
      repeat (2) begin
         @(negedge clk);
         check("pre_flush_stall", 64'(res_valid), 64'd0);
      end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("flush_ready", 64'(br_ready), 64'd1);
      check("flush_valid", 64'(res_valid), 64'd0);
      tick();
      flush = 1'b1; br_valid = 1'b1; br_bank = 0; br_cond = 4'b0000;
      tick();
      flush = 1'b0; br_valid = 1'b0;
      @(negedge clk);
      check("flush_no_capture", 64'(br_ready), 64'd1);
      tick();
      send_br(0, 4'b0011, 1'b1, 32'h0000_5000, 32'h0000_5004, 1'b1, 1'b1);
      wait_done();

      // bank independence
      pend_inc(0);
      send_br(1, 4'b0000, 1'b0, 32'h0000_6001, 32'h0000_6004, 1'b1, 1'b1);
      wait_done();
      set_flags(0, 4'b0001);

      // reset asserted mid-EVAL
      pend_inc(1);
      send_br(1, 4'b0000, 1'b1, 32'h0000_7000, 32'h0000_7004, 1'b1, 1'b0);
      @(negedge clk);
      check("pre_rst_ready", 64'(br_ready), 64'd0);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 64'(br_ready), 64'd1);
      check("mid_rst_valid", 64'(res_valid), 64'd0);
      check("mid_rst_taken", 64'(res_taken), 64'd0);
      check("mid_rst_mis", 64'(res_mispredict), 64'd0);
      check("mid_rst_pc", 64'(res_pc), 64'd0);
      check("mid_rst_full", 64'(cc_pend_full), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send_br(0, 4'b0011, 1'b1, 32'h0000_8000, 32'h0000_8004, 1'b0, 1'b1);
      wait_done();
      send_br(1, 4'b0000, 1'b0, 32'h0000_9000, 32'h0000_9004, 1'b1, 1'b1);
      wait_done();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
